// File: rtl/operand_seq.sv
// Two-press operand sequencer feeding an external 4-bit add/subtract stage; result valid 2 edges after the B press.
// No flow control: button presses are edge-detected and ignored in CALC; OPSEQ_ACCUM_EN chains the result into A.
module operand_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_i,
    input  logic       op_i,
    input  logic       btn_i,
    input  logic       clr_i,
    output logic [3:0] a_o,
    output logic [3:0] b_o,
    output logic       m_o,
    input  logic [3:0] s_i,
    input  logic       c_i,
    input  logic       v_i,
    output logic [3:0] res_o,
    output logic       carry_o,
    output logic       ovf_o,
    output logic       valid_o,
    output logic [1:0] state_o,
    output logic [7:0] cnt_o
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD_B = 2'd1;
    localparam logic [1:0] CALC   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0] state_q, state_d;
    logic [3:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic       m_q, m_d, carry_q, carry_d, ovf_q, ovf_d, valid_q, valid_d;
    logic [7:0] cnt_q, cnt_d;
    logic       btn_q;
    logic       press;
    logic [3:0] a_next_src;

    assign press = btn_i & ~btn_q;

`ifdef OPSEQ_ACCUM_EN
    assign a_next_src = res_q;
`else
    assign a_next_src = sw_i;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        res_d   = res_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            // Clear wins over any pending press or capture.
            state_d = IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (press) begin
                        a_d     = sw_i;
                        state_d = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (press) begin
                        b_d     = sw_i;
                        m_d     = op_i;
                        state_d = CALC;
                    end
                end
                CALC: begin
                    res_d   = s_i;
                    carry_d = c_i;
                    ovf_d   = v_i;
                    valid_d = 1'b1;
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    state_d = DONE;
                end
                default: begin
                    if (press) begin
                        a_d     = a_next_src;
                        valid_d = 1'b0;
                        state_d = LOAD_B;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            m_q     <= 1'b0;
            res_q   <= 4'd0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= 8'd0;
            btn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            btn_q   <= btn_i;
        end
    end

    assign a_o     = a_q;
    assign b_o     = b_q;
    assign m_o     = m_q;
    assign res_o   = res_q;
    assign carry_o = carry_q;
    assign ovf_o   = ovf_q;
    assign valid_o = valid_q;
    assign state_o = state_q;
    assign cnt_o   = cnt_q;
endmodule
